// File: rtl/serial_adder_ctrl.sv
// Bit-serial add sequencer around an external single-bit full adder, LSB first.
// Optional signed-overflow flag is built only when SERIAL_ADDER_OVF_EN is defined.
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  input  logic             c_in,
  output logic             fa_a,
  output logic             fa_b,
  output logic             fa_cin,
  input  logic             fa_sum,
  input  logic             fa_cout,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_sum_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic             r_busy;
  logic             r_done;
  logic [WIDTH-1:0] r_sum;
  logic             r_c_out;
  logic             w_run;
  logic [WIDTH-1:0] w_sum_next;

  assign w_run = (r_state == S_RUN);

  // New sum bit enters at the MSB; after WIDTH shifts bit 0 sits at the LSB.
  assign w_sum_next = (r_sum_sh >> 1) | {fa_sum, {(WIDTH-1){1'b0}}};

  assign fa_a   = w_run ? r_a_sh[0] : 1'b0;
  assign fa_b   = w_run ? r_b_sh[0] : 1'b0;
  assign fa_cin = w_run ? r_carry   : 1'b0;

  assign busy  = r_busy;
  assign done  = r_done;
  assign sum   = r_sum;
  assign c_out = r_c_out;

`ifdef SERIAL_ADDER_OVF_EN
  logic r_ovf;
  assign ovf = r_ovf;
`else
  assign ovf = 1'b0;
`endif

  // Sequencer FSM with operand shifters, carry feedback and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_a_sh   <= {WIDTH{1'b0}};
      r_b_sh   <= {WIDTH{1'b0}};
      r_sum_sh <= {WIDTH{1'b0}};
      r_carry  <= 1'b0;
      r_cnt    <= {CW{1'b0}};
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_sum    <= {WIDTH{1'b0}};
      r_c_out  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      r_ovf    <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a_sh  <= a_in;
            r_b_sh  <= b_in;
            r_carry <= c_in;
            r_cnt   <= {CW{1'b0}};
            r_busy  <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_sum_sh <= w_sum_next;
          r_carry  <= fa_cout;
          r_a_sh   <= r_a_sh >> 1;
          r_b_sh   <= r_b_sh >> 1;
          if (r_cnt == LAST_BIT) begin
            r_sum   <= w_sum_next;
            r_c_out <= fa_cout;
`ifdef SERIAL_ADDER_OVF_EN
            // r_carry here is the carry into the MSB position.
            r_ovf   <= r_carry ^ fa_cout;
`endif
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_DONE;
          end else begin
            r_cnt   <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
            r_state <= S_RUN;
          end
        end
        S_DONE: begin
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
